// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode and FSM state encodings shared by the
// multiply/divide unit and its divider step.
package mdu_pkg;

  localparam int MDU_W = 32;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_madd(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: one combinational restoring-division step.
// Ports: rem_i/quo_i/dvs_i in, rem_o/quo_o out (next partial state).
module mdu_divider
  import mdu_pkg::*;
(
  input  logic [MDU_W-1:0] rem_i,
  input  logic [MDU_W-1:0] quo_i,
  input  logic [MDU_W-1:0] dvs_i,
  output logic [MDU_W-1:0] rem_o,
  output logic [MDU_W-1:0] quo_o
);

  logic [MDU_W:0] trial;
  logic [MDU_W:0] diff;
  logic           ge;

  // Dividend bits shift out of the quotient MSB into the remainder;
  // a zero divisor always "fits", giving all-ones quotient and rem=a.
  always_comb begin
    trial = {rem_i, quo_i[MDU_W-1]};
    diff  = trial - {1'b0, dvs_i};
    ge    = (trial >= {1'b0, dvs_i});
    rem_o = ge ? diff[MDU_W-1:0] : trial[MDU_W-1:0];
    quo_o = {quo_i[MDU_W-2:0], ge};
  end

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle MUL/DIV unit owning HI/LO; drives stall/done
// to the hazard unit. Ports: clk, rst, start, op, a, b, flush -> stall,
// done, busy, hi, lo. Macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_ITER = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [MDU_W-1:0] a,
  input  logic [MDU_W-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic             busy,
  output logic [MDU_W-1:0] hi,
  output logic [MDU_W-1:0] lo
);

  localparam int CW = 6;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_ITER - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic [MDU_W-1:0] dvs_q, dvs_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [MDU_W-1:0] hi_q, hi_d;
  logic [MDU_W-1:0] lo_q, lo_d;

  logic             mul_op, div_op, acc_op, multi, sgn;
  logic [63:0]      ax, bx, prod, wr_val;
  logic [MDU_W-1:0] a_abs, b_abs;
  logic [MDU_W-1:0] step_rem, step_quo;
  logic [MDU_W-1:0] fix_rem, fix_quo;

`ifdef MDU_MADD_EN
  logic [3:0] op_q, op_d;
`endif

  mdu_divider u_div (
    .rem_i (res_q[63:32]),
    .quo_i (res_q[31:0]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    mul_op = is_mul(op);
    div_op = is_div(op);
`ifdef MDU_MADD_EN
    acc_op = is_madd(op);
`else
    acc_op = 1'b0;
`endif
    multi  = mul_op | div_op | acc_op;
    sgn    = is_signed_op(op);
    ax     = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    bx     = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    // Low 64 bits of the extended product are exact for both signednesses.
    prod   = ax * bx;
    a_abs  = (sgn && a[31]) ? -a : a;
    b_abs  = (sgn && b[31]) ? -b : b;
    fix_rem = sa_q ? -res_q[63:32] : res_q[63:32];
    if (dvs_q == '0)
      fix_quo = '1;
    else
      fix_quo = (sa_q ^ sb_q) ? -res_q[31:0] : res_q[31:0];
  end

  always_comb begin
    wr_val = res_q;
`ifdef MDU_MADD_EN
    if ((op_q == OP_MADD) || (op_q == OP_MADDU))
      wr_val = {hi_q, lo_q} + res_q;
    else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
      wr_val = {hi_q, lo_q} - res_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_MADD_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (mul_op || acc_op) begin
`ifdef MDU_MADD_EN
            op_d = op;
`endif
            res_d   = prod;
            cnt_d   = MUL_CNT;
            state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
          end else if (div_op) begin
`ifdef MDU_MADD_EN
            op_d = op;
`endif
            res_d   = {32'b0, a_abs};
            dvs_d   = b_abs;
            sa_d    = sgn & a[31];
            sb_d    = sgn & b[31];
            cnt_d   = DIV_CNT;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DIV: begin
        res_d = {step_rem, step_quo};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = {fix_rem, fix_quo};
        state_d = S_DONE;
      end
      S_DONE: begin
        {hi_d, lo_d} = wr_val;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_MADD_EN
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_MADD_EN
      op_q    <= op_d;
`endif
    end
  end

  assign stall = ((state_q == S_IDLE) && start && multi) ||
                 (state_q == S_MUL) || (state_q == S_DIV) ||
                 (state_q == S_FIX);
  assign done  = (state_q == S_DONE) && !flush;
  assign busy  = (state_q != S_IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: random + directed scoreboard bench for mdu_iterative.
// Expected HI/LO come from a plain-arithmetic reference model.
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_STALL = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush = 1'b0;
  logic        stall, done, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_iterative #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i),
    .a(a_i), .b(b_i), .flush(flush),
    .stall(stall), .done(done), .busy(busy),
    .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [3:0] o,
      input logic [31:0] x, input logic [31:0] y,
      input logic [31:0] h, input logic [31:0] l);
    longint p;
    logic [63:0] u;
    int q, r;
    p = longint'($signed(x)) * longint'($signed(y));
    u = {32'b0, x} * {32'b0, y};
    case (o)
      OP_MULT:  return p;
      OP_MULTU: return u;
      OP_MADD:  return {h, l} + p;
      OP_MADDU: return {h, l} + u;
      OP_MSUB:  return {h, l} - p;
      OP_MSUBU: return {h, l} - u;
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      OP_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {h, l};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest queued result.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=%h want=none", {hi, lo});
        end else begin
          e = exp_q.pop_front();
          chk("done_hilo", {hi, lo}, e);
        end
      end
    end
  end

  task automatic run_multi(input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int exp_stall);
    int stl, dcyc;
    logic [63:0] r;
    r = ref_op(o, x, y, m_hi, m_lo);
    exp_q.push_back(r);
    {m_hi, m_lo} = r;
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = x; b_i = y;
    stl = 0;
    dcyc = 0;
    for (int c = 1; c <= 100; c++) begin
      #1;
      if (stall) stl++;
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_cycles", 64'(stl), 64'(exp_stall));
    chk("done_cycle", 64'(dcyc), 64'(exp_stall + 1));
    @(negedge clk);
    #1;
    chk("done_pulse_idle", {62'b0, done, busy}, 64'b0);
  endtask

  task automatic run_single(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = x; b_i = $urandom;
    #1;
    chk("no_stall", {63'b0, stall}, 64'b0);
    if (o == OP_MTHI) m_hi = x;
    if (o == OP_MTLO) m_lo = x;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("single_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic int lat_of(input logic [3:0] o);
    return (o == OP_DIV || o == OP_DIVU) ? DIV_STALL : MUL_LAT;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops[6];
    logic [3:0] o;
    logic [31:0] x, y;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    #3;
    chk("reset_hilo", {hi, lo}, 64'b0);
    chk("reset_ctl", {61'b0, stall, done, busy}, 64'b0);
    @(negedge clk);
    rst = 1'b0;

    run_multi(OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_LAT);
    chk("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_multi(OP_DIVU, 32'd100, 32'd7, DIV_STALL);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run_multi(OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_STALL);
    chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_multi(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_multi(OP_DIVU, 32'd5, 32'd0, DIV_STALL);
    chk("divu_by0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    checks++;
    if ($isunknown({hi, lo, stall, done, busy})) begin
      failures++;
      $display("FAIL x_outputs got=%h want=known", {hi, lo});
    end
    run_multi(OP_DIV, 32'hFFFF_FFF0, 32'd0, DIV_STALL);

    run_single(OP_MTHI, 32'h0);
    run_single(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_multi(OP_MADDU, 32'd1, 32'd1, MUL_LAT);
    chk("maddu", {hi, lo}, {32'd1, 32'd0});
`else
    run_single(OP_MADDU, 32'd1);
    chk("maddu_nop", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

    @(negedge clk);
    start = 1'b1; op_i = OP_DIV; a_i = 32'd999; b_i = 32'd3;
    repeat (10) @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle", {63'b0, busy}, 64'b0);
    chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
    run_single(OP_MTLO, 32'd1234);
    repeat (40) @(negedge clk);
    chk("flush_quiet", {63'b0, busy}, 64'b0);

    for (int i = 0; i < 30; i++) begin
      o = ops[$urandom_range(0, 5)];
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if (o == OP_MTHI || o == OP_MTLO) run_single(o, x);
      else run_multi(o, x, y, lat_of(o));
    end

    @(negedge clk);
    start = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd5;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_op", {hi, lo, 31'b0, busy}, 95'b0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
